// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter: shares a single write-first BRAM port between two
// requesters. A combinational round-robin arbiter grants at most one request
// per cycle. The grant drives the BRAM port in the same cycle. A two-stage tag
// pipeline routes the registered BRAM read data back to the requester that
// was granted, so the response arrives two cycles after acceptance.
module bram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int NB_COL    = 4,
    parameter int COL_WIDTH = 9,
    parameter int LATENCY   = 2
) (
    input  logic                        clk,
    input  logic                        rst,

    // Requester 0
    input  logic                        req0_valid,
    output logic                        req0_ready,
    input  logic [ADDR_W-1:0]           req0_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] req0_wdata,
    input  logic [NB_COL-1:0]           req0_wstrb,

    // Requester 1
    input  logic                        req1_valid,
    output logic                        req1_ready,
    input  logic [ADDR_W-1:0]           req1_addr,
    input  logic [NB_COL*COL_WIDTH-1:0] req1_wdata,
    input  logic [NB_COL-1:0]           req1_wstrb,

    // Responses (no backpressure)
    output logic                        resp0_valid,
    output logic [NB_COL*COL_WIDTH-1:0] resp0_rdata,
    output logic                        resp1_valid,
    output logic [NB_COL*COL_WIDTH-1:0] resp1_rdata,

    // Write-first BRAM port with output register
    output logic                        bram_en,
    output logic [NB_COL-1:0]           bram_we,
    output logic [ADDR_W-1:0]           bram_addr,
    output logic [NB_COL*COL_WIDTH-1:0] bram_din,
    output logic                        bram_regce,
    output logic                        bram_rst,
    input  logic [NB_COL*COL_WIDTH-1:0] bram_dout
);

    localparam int DATA_W = NB_COL * COL_WIDTH;

    // The tag pipeline depth is tied to the BRAM primitive configuration
    // (address register + output register). Any other value would return
    // data on the wrong cycle.
    if (LATENCY != 2) begin : g_latency_check
        $error("bram_port_arbiter: LATENCY must be 2");
    end

    // Identifies a requester. It is used both for the priority pointer and for
    // the response routing tags.
    typedef enum logic {
        REQ0 = 1'b0,
        REQ1 = 1'b1
    } req_id_e;

    // One entry of the response-routing pipeline.
    typedef struct packed {
        logic    valid;
        req_id_e id;
    } tag_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    req_id_e prio_q, prio_d;      // requester that wins the next contended cycle
    tag_t    stage1_q, stage1_d;  // tag for data in the BRAM output latch
    tag_t    stage2_q, stage2_d;  // tag for data on bram_dout

    // Arbitration results for the current cycle
    logic    grant_valid;
    req_id_e grant_id;

    // Muxed request fields of the granted requester
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic [NB_COL-1:0] sel_wstrb;

    // ------------------------------------------------------------------
    // Arbitration: a single requester wins outright. On contention, the
    // priority pointer decides and then flips to the loser. Reset masks every
    // grant, so nothing is accepted while rst is high.
    // ------------------------------------------------------------------
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a variable unassigned and no latch is inferred.
        grant_valid = 1'b0;
        grant_id    = REQ0;
        prio_d      = prio_q;

        if (!rst) begin
            unique case ({req1_valid, req0_valid})
                2'b01: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ0;
                end
                2'b10: begin
                    grant_valid = 1'b1;
                    grant_id    = REQ1;
                end
                2'b11: begin
                    grant_valid = 1'b1;
                    grant_id    = prio_q;
                    prio_d      = (prio_q == REQ0) ? REQ1 : REQ0;
                end
                default: begin
                    grant_valid = 1'b0;
                end
            endcase
        end
    end

    // Ready is a pure function of the grant. Because the grant is gated by
    // rst and by the request valids, ready can never assert without valid.
    assign req0_ready = grant_valid && (grant_id == REQ0);
    assign req1_ready = grant_valid && (grant_id == REQ1);

    // ------------------------------------------------------------------
    // Request mux: forward the granted request to the BRAM port in the same
    // cycle. The address and data may carry a don't-care value when idle, but
    // the enables are forced low.
    // ------------------------------------------------------------------
    always_comb begin
        sel_addr  = req0_addr;
        sel_wdata = req0_wdata;
        sel_wstrb = req0_wstrb;
        if (grant_id == REQ1) begin
            sel_addr  = req1_addr;
            sel_wdata = req1_wdata;
            sel_wstrb = req1_wstrb;
        end
    end

    assign bram_en   = grant_valid;
    assign bram_we   = grant_valid ? sel_wstrb : '0;
    assign bram_addr = sel_addr;
    assign bram_din  = sel_wdata;

    // ------------------------------------------------------------------
    // Tag pipeline next state: the grant enters stage 1 and stage 1 moves to
    // stage 2. Both reads and writes carry a tag, because a write also
    // returns the write-first word.
    // ------------------------------------------------------------------
    always_comb begin
        stage1_d = '{valid: grant_valid, id: grant_id};
        stage2_d = stage1_q;
    end

    // Registers the priority pointer and the tag pipeline. Reset discards any
    // request that is still in flight.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments, so that every
        // register samples its pre-edge value. Blocking assignments here would
        // let stage2 pick up this edge's stage1 value and skip a stage.
        if (rst) begin
            prio_q   <= REQ0;
            stage1_q <= '0;
            stage2_q <= '0;
        end else begin
            prio_q   <= prio_d;
            stage1_q <= stage1_d;
            stage2_q <= stage2_d;
        end
    end

    // ------------------------------------------------------------------
    // BRAM output register control and response routing. Gating with rst
    // keeps regce and the response pulses low for the whole reset window,
    // including the first reset cycle, before the stages have cleared.
    // ------------------------------------------------------------------
    assign bram_rst    = rst;
    assign bram_regce  = stage1_q.valid && !rst;

    assign resp0_valid = stage2_q.valid && (stage2_q.id == REQ0) && !rst;
    assign resp1_valid = stage2_q.valid && (stage2_q.id == REQ1) && !rst;

    // Only one response is outstanding per cycle, so both requesters can share
    // the registered BRAM output. The data is meaningful only while the
    // matching respN_valid is high.
    assign resp0_rdata = bram_dout;
    assign resp1_rdata = bram_dout;

    // ------------------------------------------------------------------
    // Structural invariants of the arbiter and the response path.
    // ------------------------------------------------------------------
    a_ready_onehot: assert property (@(posedge clk) !(req0_ready && req1_ready));
    a_ready0_valid: assert property (@(posedge clk) req0_ready |-> req0_valid);
    a_ready1_valid: assert property (@(posedge clk) req1_ready |-> req1_valid);
    a_resp_onehot:  assert property (@(posedge clk) !(resp0_valid && resp1_valid));

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter: randomized and directed stimulus for
// bram_port_arbiter, checked against a behavioural reference model.
// The reference model contains a round-robin rule, a reference memory, and a
// queue of expected responses that carry their due cycle. A separate monitor
// pops and compares entries whenever the DUT presents a response.
module tb_bram_port_arbiter;

    localparam int ADDR_W    = 10;
    localparam int NB_COL    = 4;
    localparam int COL_WIDTH = 9;
    localparam int DATA_W    = NB_COL * COL_WIDTH;
    localparam int DEPTH     = 1 << ADDR_W;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [NB_COL-1:0] wstrb;
    } req_t;

    typedef struct {
        int                id;
        logic [DATA_W-1:0] data;
        int                due;
    } exp_t;

    logic              clk;
    logic              rst;
    logic              req0_valid, req0_ready, req1_valid, req1_ready;
    logic [ADDR_W-1:0] req0_addr, req1_addr;
    logic [DATA_W-1:0] req0_wdata, req1_wdata;
    logic [NB_COL-1:0] req0_wstrb, req1_wstrb;
    logic              resp0_valid, resp1_valid;
    logic [DATA_W-1:0] resp0_rdata, resp1_rdata;
    logic              bram_en, bram_regce, bram_rst;
    logic [NB_COL-1:0] bram_we;
    logic [ADDR_W-1:0] bram_addr;
    logic [DATA_W-1:0] bram_din, bram_dout;

    int errors = 0;
    int checks = 0;
    int cycle  = 0;

    req_t q0[$];
    req_t q1[$];
    exp_t exp_q[$];

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] bmem    [DEPTH];
    logic [DATA_W-1:0] blat;

    bram_port_arbiter #(
        .ADDR_W(ADDR_W), .NB_COL(NB_COL), .COL_WIDTH(COL_WIDTH), .LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_wstrb(req0_wstrb),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_wstrb(req1_wstrb),
        .resp0_valid(resp0_valid), .resp0_rdata(resp0_rdata),
        .resp1_valid(resp1_valid), .resp1_rdata(resp1_rdata),
        .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr), .bram_din(bram_din),
        .bram_regce(bram_regce), .bram_rst(bram_rst), .bram_dout(bram_dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cycle, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] init_word(input int a);
        logic [ADDR_W-1:0] av;
        av = ADDR_W'(a);
        if (a == 5) return 36'h123456789;
        return {6'h15, av, ~av, av ^ 10'h155};
    endfunction

    function automatic logic [DATA_W-1:0] merge(input logic [DATA_W-1:0] old, input req_t r);
        logic [DATA_W-1:0] w;
        w = old;
        for (int l = 0; l < NB_COL; l++)
            if (r.wstrb[l]) w[l*COL_WIDTH +: COL_WIDTH] = r.wdata[l*COL_WIDTH +: COL_WIDTH];
        return w;
    endfunction

    function automatic req_t rand_req();
        req_t r;
        r.addr  = ($urandom_range(3) == 0) ? 10'h3FF : 10'($urandom_range(15));
        r.wdata = {4'($urandom), 32'($urandom)};
        r.wstrb = ($urandom_range(99) < 35) ? 4'($urandom_range(15, 1)) : 4'h0;
        return r;
    endfunction

    // Behavioural write-first BRAM with an output register. It stands in for
    // the memory primitive that the block drives.
    initial for (int a = 0; a < DEPTH; a++) begin
        bmem[a]    = init_word(a);
        ref_mem[a] = init_word(a);
    end

    always @(posedge clk) begin
        logic [DATA_W-1:0] w;
        if (bram_en) begin
            w = bmem[bram_addr];
            for (int l = 0; l < NB_COL; l++)
                if (bram_we[l]) w[l*COL_WIDTH +: COL_WIDTH] = bram_din[l*COL_WIDTH +: COL_WIDTH];
            bmem[bram_addr] <= w;
            blat            <= w;
        end
        if (bram_rst)        bram_dout <= '0;
        else if (bram_regce) bram_dout <= blat;
    end

    // Reference model: evaluates the arbitration rules once per cycle on the
    // falling edge, checks the combinational outputs, and schedules each
    // expected response two cycles after its grant.
    bit m_prio;
    bit m_prev_grant;
    initial begin
        m_prio       = 1'b0;
        m_prev_grant = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                check("rst_req0_ready", req0_ready, 0);
                check("rst_req1_ready", req1_ready, 0);
                check("rst_bram_en", bram_en, 0);
                check("rst_bram_we", bram_we, 0);
                check("rst_bram_regce", bram_regce, 0);
                check("rst_bram_rst", bram_rst, 1);
                check("rst_resp0", resp0_valid, 0);
                check("rst_resp1", resp1_valid, 0);
                exp_q.delete();
                m_prio       = 1'b0;
                m_prev_grant = 1'b0;
            end else begin
                int   g;
                req_t r;
                exp_t e;
                g = -1;
                if (req0_valid && req1_valid) begin
                    g      = int'(m_prio);
                    m_prio = ~m_prio;
                end else if (req0_valid) g = 0;
                else if (req1_valid)     g = 1;

                check("req0_ready", req0_ready, g == 0);
                check("req1_ready", req1_ready, g == 1);
                check("bram_rst", bram_rst, 0);
                check("bram_regce", bram_regce, m_prev_grant);
                check("bram_en", bram_en, g >= 0);
                if (g >= 0) begin
                    if (g == 0) r = '{addr: req0_addr, wdata: req0_wdata, wstrb: req0_wstrb};
                    else        r = '{addr: req1_addr, wdata: req1_wdata, wstrb: req1_wstrb};
                    check("bram_addr", bram_addr, r.addr);
                    check("bram_we", bram_we, r.wstrb);
                    if (r.wstrb != 0) check("bram_din", bram_din, r.wdata);
                    ref_mem[r.addr] = merge(ref_mem[r.addr], r);
                    e.id   = g;
                    e.data = ref_mem[r.addr];
                    e.due  = cycle + 2;
                    exp_q.push_back(e);
                end else begin
                    check("bram_we_idle", bram_we, 0);
                end
                m_prev_grant = (g >= 0);
            end
        end
    end

    // Monitor: compares every response pulse against the head of the
    // expected queue and flags any response that is missing or late.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            #1;
            check("resp_onehot", resp0_valid & resp1_valid, 0);
            if (resp0_valid || resp1_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL resp_unexpected @cycle %0d: got resp0=%0b resp1=%0b expected none",
                             cycle, resp0_valid, resp1_valid);
                end else begin
                    e = exp_q.pop_front();
                    check("resp_id", resp1_valid, e.id);
                    check("resp_data", resp1_valid ? resp1_rdata : resp0_rdata, e.data);
                    check("resp_cycle", cycle, e.due);
                end
            end else if (exp_q.size() != 0 && exp_q[0].due <= cycle) begin
                e = exp_q.pop_front();
                checks++;
                errors++;
                $display("FAIL resp_missing @cycle %0d: got no response expected id %0d data %0h",
                         cycle, e.id, e.data);
            end
        end
    end

    task automatic apply_heads();
        req0_valid = (q0.size() != 0);
        req1_valid = (q1.size() != 0);
        if (req0_valid) begin
            req0_addr  = q0[0].addr;
            req0_wdata = q0[0].wdata;
            req0_wstrb = q0[0].wstrb;
        end
        if (req1_valid) begin
            req1_addr  = q1[0].addr;
            req1_wdata = q1[0].wdata;
            req1_wstrb = q1[0].wstrb;
        end
    endtask

    // Presents queued requests and holds each one until it is accepted. For
    // the first rand_cycles cycles, an empty queue is refilled at random with
    // probability p0/p1 percent.
    task automatic drive(input int rand_cycles, input int p0, input int p1);
        int n;
        bit a0, a1;
        n = 0;
        apply_heads();
        while (n < rand_cycles || req0_valid || req1_valid) begin
            if (n >= rand_cycles + 200) begin
                checks++;
                errors++;
                $display("FAIL stream_timeout: got %0d/%0d pending expected 0", q0.size(), q1.size());
                q0.delete();
                q1.delete();
                apply_heads();
                break;
            end
            @(negedge clk);
            a0 = req0_ready;
            a1 = req1_ready;
            @(posedge clk);
            #1;
            if (a0 && q0.size() != 0) void'(q0.pop_front());
            if (a1 && q1.size() != 0) void'(q1.pop_front());
            if (n < rand_cycles) begin
                if (q0.size() == 0 && $urandom_range(99) < p0) q0.push_back(rand_req());
                if (q1.size() == 0 && $urandom_range(99) < p1) q1.push_back(rand_req());
            end
            apply_heads();
            n++;
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst        = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_addr  = '0;
        req1_addr  = '0;
        req0_wdata = '0;
        req1_wdata = '0;
        req0_wstrb = '0;
        req1_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Single read of a known word
        q0.push_back('{addr: 10'h005, wdata: '0, wstrb: 4'h0});
        drive(0, 0, 0);
        idle(4);

        // Contention straight after reset: grants alternate, starting with 0
        pulse_reset();
        for (int i = 0; i < 4; i++) begin
            q0.push_back('{addr: 10'(16 + i), wdata: '0, wstrb: 4'h0});
            q1.push_back('{addr: 10'(32 + i), wdata: '0, wstrb: 4'h0});
        end
        drive(0, 0, 0);
        idle(4);

        // Lane-2 write at the top address, then read back
        q1.push_back('{addr: 10'h3FF, wdata: 36'h007FC0000, wstrb: 4'b0100});
        q1.push_back('{addr: 10'h3FF, wdata: '0, wstrb: 4'h0});
        drive(0, 0, 0);
        idle(4);

        // Sustained back-to-back reads of addresses 0..15
        for (int i = 0; i < 16; i++) q0.push_back('{addr: 10'(i), wdata: '0, wstrb: 4'h0});
        drive(0, 0, 0);
        idle(4);

        // Reset one cycle after a grant discards the response; priority restarts at 0
        req0_valid = 1'b1;
        req0_addr  = 10'h007;
        req0_wstrb = 4'h0;
        @(posedge clk);
        #1;
        req0_valid = 1'b0;
        pulse_reset();
        q0.push_back('{addr: 10'h008, wdata: '0, wstrb: 4'h0});
        q1.push_back('{addr: 10'h009, wdata: '0, wstrb: 4'h0});
        drive(0, 0, 0);
        idle(4);

        // Requester 1 silent while requester 0 is active
        drive(60, 80, 0);
        idle(4);

        // Fully random traffic on both requesters
        drive(400, 60, 60);
        idle(6);

        check("drain", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running expected finished");
        $fatal(1, "watchdog");
    end

endmodule
